multi_channel_slave_fifo: RTL and testbench
===========================================

// Module: multi_channel_slave_fifo
// PURPOSE
//  Next-generation FX2 slave-FIFO bridge: N_CH SPI channels share one 16-bit Cypress slave FIFO.
//  Upstream: arbitrates complete messages from the per-channel input FIFOs and writes them
//  to EP6 (IN) with a channel header.
//  Downstream: reads headered messages from EP2 (OUT) and routes each word to the addressed
//  channel's serializer.
//  Sits between the input_process_spi / output_process_spi instances and the FD/flag pins.
// PARAMETERS
//  N_CH     4    number of SPI channels (1..16)
//  CH_W     2    channel index width, = clog2(N_CH), min 1
//  LEN_W    8    message length width in words (header low byte; LEN_W<=8)
//  EP_OUT   2'b00  FIFOADR value for host->FPGA endpoint (EP2)
//  EP_IN    2'b10  FIFOADR value for FPGA->host endpoint (EP6)
// PORTS
//  CLK          in   1           IFCLK domain clock; all logic on rising edge
//  RST          in   1           asynchronous, active-high reset
//  FLAG_EMPTY   in   1           EP_OUT empty flag, active-low (0 = empty)
//  FLAG_FULL    in   1           EP_IN full flag, active-low (0 = full)
//  FD_IN        in   16          FD bus sampled, big-endian (byte swap done at top)
//  FD_OUT       out  16          FD bus driven value
//  FD_OE        out  1           1 = top level drives FD with FD_OUT
//  SLOE/SLRD/SLWR/PKTEND out 1   Cypress strobes, active-low
//  FIFOADR      out  2           endpoint select
//  GOT_FULL_MSG in   N_CH        channel c holds a complete message
//  MSG_LEN      in   N_CH*LEN_W  per-channel length in words, slice c
//  FIFO_Q       in   N_CH*16     per-channel show-ahead FIFO head, slice c
//  RD_REQ       out  N_CH        pop one word from channel c
//  MSG_SENT     out  N_CH        1-cycle pulse: channel c message fully written
//  DOUT         out  16          word to serializers
//  ENA          out  N_CH        1-cycle load strobe to serializer c
//  BUSY         in   N_CH        serializer c busy; no ENA while high
//  DROP_CNT     out  8           saturating count of messages with ch_id >= N_CH
// BEHAVIOUR
//  - Reset: all strobes 1, FIFOADR=EP_OUT, FD_OE=0, FD_OUT=0, RD_REQ/MSG_SENT/ENA=0,
//    DOUT=0, DROP_CNT=0, state IDLE, RR pointer=0. Reset mid-transfer aborts at once.
//    The partial packet is abandoned; no MSG_SENT.
//  - Header word: {ch_id[7:0], len[7:0]}, same format both directions. Then len data words.
//    len=0 is legal (header only).
//  - IDLE: write has priority: any GOT_FULL_MSG & FLAG_FULL=1 -> ARB;
//    else FLAG_EMPTY=1 -> RD_TURN; else stay.
//  - ARB: round-robin grant starting at ptr. Latch ch and len=MSG_LEN[ch].
//    Set ptr=ch+1 (wraps mod N_CH). Set FIFOADR=EP_IN, FD_OE=1. -> WR_TURN.
//  - WR_TURN: 1 cycle for FIFOADR setup -> WR_HDR.
//  - WR_HDR: when FLAG_FULL=1: FD_OUT=header, SLWR=0 for 1 cycle.
//    -> WR_DATA (or WR_END if len=0).
//  - WR_DATA: per word, when FLAG_FULL=1: FD_OUT=FIFO_Q[ch], SLWR=0 and RD_REQ[ch]=1 same cycle.
//    Decrement count. When FLAG_FULL=0, hold with strobes high.
//    After last word -> WR_END.
//  - WR_END: MSG_SENT[ch]=1 (1 cycle) plus PKTEND option. Then FD_OE=0, FIFOADR=EP_OUT -> IDLE.
//  - RD_TURN: FIFOADR=EP_OUT, SLOE=0, 1 setup cycle -> RD_HDR.
//    SLOE stays low for the whole read.
//  - RD_HDR: when FLAG_EMPTY=1: latch FD_IN, SLRD=0 1 cycle.
//    If ch_id>=N_CH, mark drop and DROP_CNT++ (saturate at 255). -> RD_DATA (len=0 -> IDLE).
//  - RD_DATA: per word, wait FLAG_EMPTY=1 AND (BUSY[ch]=0 or drop).
//    Then DOUT=FD_IN, ENA[ch]=1 (suppressed if drop), SLRD=0, same cycle.
//    Next word not before BUSY[ch] is sampled (1 cycle gap min).
//    After last word SLOE=1 -> IDLE.
//  - Strobe spacing: SLRD/SLWR are never low 2 consecutive cycles. Max 1 word per 2 CLK.
//    RD_REQ/ENA are 1-cycle pulses aligned with the strobe.
//  - Flags sampled registered. An in-progress message always completes before direction changes.
//    GOT_FULL_MSG arriving during a read waits.
//  - MSG_LEN/FIFO_Q are only trusted while GOT_FULL_MSG[ch]=1 at ARB.
// CONFIGURATION
//  MCSF_PKTEND_EN defined:
//   - In WR_END, PKTEND=0 for 1 cycle, with FIFOADR still EP_IN. This commits short packets immediately.
//  Not defined:
//   - PKTEND tied 1.
//   - EP_IN commits only full packets (host uses auto-commit/timeouts).
// TESTING
//  1. Reset: assert RST mid WR_DATA -> all strobes 1, FD_OE=0, RD_REQ=0, no MSG_SENT.
//  2. Ch2 GOT_FULL_MSG, len=3, FLAG_FULL=1 -> EP_IN writes {02,03} then 3 words.
//     3 RD_REQ[2] pulses, MSG_SENT[2] once. With _EN, 1 PKTEND pulse.
//  3. Ch0 and ch3 ready together, ptr=0 -> ch0 served first, then ch3. Ptr ends at 0 (wrap).
//  4. Host sends {01,02},A5A5,5A5A; hold BUSY[1]=1 for 10 cycles -> ENA[1] waits.
//     DOUT=A5A5 then 5A5A, 2 SLRD pulses after header.
//  5. Header {07,02} with N_CH=4 -> 3 SLRD pulses, no ENA, DROP_CNT=1.
//  6. FLAG_FULL=0 mid-message for 5 cycles -> SLWR held 1, no RD_REQ. Resume without word loss.

Source files
------------

// File: rtl/multi_channel_slave_fifo.sv
// Bridges N_CH SPI channel FIFOs/serializers to one 16-bit FX2 slave FIFO (EP_IN up, EP_OUT down).
// Optional MCSF_PKTEND_EN: pulse PKTEND after each upstream message so short packets commit at once.
module multi_channel_slave_fifo #(
  parameter int         N_CH   = 4,
  parameter int         CH_W   = 2,
  parameter int         LEN_W  = 8,
  parameter logic [1:0] EP_OUT = 2'b00,
  parameter logic [1:0] EP_IN  = 2'b10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLAG_EMPTY,
  input  logic                  FLAG_FULL,
  input  logic [15:0]           FD_IN,
  output logic [15:0]           FD_OUT,
  output logic                  FD_OE,
  output logic                  SLOE,
  output logic                  SLRD,
  output logic                  SLWR,
  output logic                  PKTEND,
  output logic [1:0]            FIFOADR,
  input  logic [N_CH-1:0]       GOT_FULL_MSG,
  input  logic [N_CH*LEN_W-1:0] MSG_LEN,
  input  logic [N_CH*16-1:0]    FIFO_Q,
  output logic [N_CH-1:0]       RD_REQ,
  output logic [N_CH-1:0]       MSG_SENT,
  output logic [15:0]           DOUT,
  output logic [N_CH-1:0]       ENA,
  input  logic [N_CH-1:0]       BUSY,
  output logic [7:0]            DROP_CNT
);

  // state   | meaning
  // IDLE    | no transfer; writes win over reads
  // ARB     | round-robin grant among channels holding a full message
  // WR_TURN | EP_IN address setup before first write strobe
  // WR_HDR  | write {ch, len} header word
  // WR_DATA | stream len words from the granted channel FIFO
  // WR_END  | report message sent, optional PKTEND request
  // WR_FIN  | PKTEND cycle (EP_IN still selected), then release the bus
  // RD_TURN | EP_OUT address / SLOE setup
  // RD_HDR  | read {ch, len} header word, classify drop
  // RD_DATA | route len words to the addressed serializer
  typedef enum logic [3:0] {
    IDLE, ARB, WR_TURN, WR_HDR, WR_DATA, WR_END, WR_FIN, RD_TURN, RD_HDR, RD_DATA
  } state_t;

  localparam int         IW       = CH_W + 1;
  localparam logic [8:0] N_CH_EXT = 9'(N_CH);

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d, ch_q, ch_d, arb_ch;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                drop_q, drop_d;
  logic                flag_empty_q, flag_full_q;
  logic [15:0]         fd_out_q, fd_out_d, dout_q, dout_d;
  logic                fd_oe_q, fd_oe_d, sloe_q, sloe_d;
  logic                slrd_q, slrd_d, slwr_q, slwr_d, pktend_q, pktend_d;
  logic [1:0]          fifoadr_q, fifoadr_d;
  logic [N_CH-1:0]     rd_req_q, rd_req_d, msg_sent_q, msg_sent_d, ena_q, ena_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic                wr_fire, rd_fire, arb_hit, hdr_drop, wr_side, rd_side;
  logic [IW-1:0]       arb_idx;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      ch_q         <= '0;
      cnt_q        <= '0;
      drop_q       <= 1'b0;
      flag_empty_q <= 1'b0;
      flag_full_q  <= 1'b0;
      fd_out_q     <= '0;
      dout_q       <= '0;
      fd_oe_q      <= 1'b0;
      sloe_q       <= 1'b1;
      slrd_q       <= 1'b1;
      slwr_q       <= 1'b1;
      pktend_q     <= 1'b1;
      fifoadr_q    <= EP_OUT;
      rd_req_q     <= '0;
      msg_sent_q   <= '0;
      ena_q        <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ch_q         <= ch_d;
      cnt_q        <= cnt_d;
      drop_q       <= drop_d;
      flag_empty_q <= FLAG_EMPTY;
      flag_full_q  <= FLAG_FULL;
      fd_out_q     <= fd_out_d;
      dout_q       <= dout_d;
      fd_oe_q      <= fd_oe_d;
      sloe_q       <= sloe_d;
      slrd_q       <= slrd_d;
      slwr_q       <= slwr_d;
      pktend_q     <= pktend_d;
      fifoadr_q    <= fifoadr_d;
      rd_req_q     <= rd_req_d;
      msg_sent_q   <= msg_sent_d;
      ena_q        <= ena_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ch_d       = ch_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    fd_out_d   = fd_out_q;
    dout_d     = dout_q;
    drop_cnt_d = drop_cnt_q;
    slwr_d     = 1'b1;
    slrd_d     = 1'b1;
    pktend_d   = 1'b1;
    rd_req_d   = '0;
    msg_sent_d = '0;
    ena_d      = '0;
    arb_hit    = 1'b0;
    arb_ch     = '0;
    arb_idx    = '0;
    // A strobe is only issued when the previous cycle had none, so the flag
    // and the FIFO heads seen here already reflect the last pop.
    wr_fire    = flag_full_q & slwr_q;
    rd_fire    = flag_empty_q & slrd_q;
    hdr_drop   = ({1'b0, FD_IN[15:8]} >= N_CH_EXT);

    for (int i = 0; i < N_CH; i++) begin
      arb_idx = {1'b0, ptr_q} + IW'(i);
      if (arb_idx >= IW'(N_CH)) arb_idx = arb_idx - IW'(N_CH);
      if (!arb_hit && GOT_FULL_MSG[arb_idx[CH_W-1:0]]) begin
        arb_hit = 1'b1;
        arb_ch  = arb_idx[CH_W-1:0];
      end
    end

    case (state_q)
      IDLE: begin
        if ((|GOT_FULL_MSG) && flag_full_q) state_d = ARB;
        else if (flag_empty_q && slrd_q)    state_d = RD_TURN;
      end
      ARB: begin
        if (arb_hit) begin
          ch_d    = arb_ch;
          cnt_d   = MSG_LEN[arb_ch*LEN_W +: LEN_W];
          ptr_d   = (arb_ch == CH_W'(N_CH - 1)) ? '0 : arb_ch + 1'b1;
          state_d = WR_TURN;
        end else begin
          state_d = IDLE;
        end
      end
      WR_TURN: state_d = WR_HDR;
      WR_HDR: begin
        if (wr_fire) begin
          fd_out_d = {8'(ch_q), 8'(cnt_q)};
          slwr_d   = 1'b0;
          state_d  = (cnt_q == '0) ? WR_END : WR_DATA;
        end
      end
      WR_DATA: begin
        if (wr_fire) begin
          fd_out_d       = FIFO_Q[ch_q*16 +: 16];
          slwr_d         = 1'b0;
          rd_req_d[ch_q] = 1'b1;
          cnt_d          = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = WR_END;
        end
      end
      WR_END: begin
        msg_sent_d[ch_q] = 1'b1;
`ifdef MCSF_PKTEND_EN
        pktend_d = 1'b0;
`endif
        state_d = WR_FIN;
      end
      WR_FIN:  state_d = IDLE;
      RD_TURN: state_d = RD_HDR;
      RD_HDR: begin
        if (rd_fire) begin
          slrd_d = 1'b0;
          ch_d   = FD_IN[8 +: CH_W];
          cnt_d  = FD_IN[LEN_W-1:0];
          drop_d = hdr_drop;
          if (hdr_drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
          state_d = (FD_IN[LEN_W-1:0] == '0) ? IDLE : RD_DATA;
        end
      end
      RD_DATA: begin
        if (rd_fire && (drop_q || !BUSY[ch_q])) begin
          slrd_d = 1'b0;
          dout_d = FD_IN;
          if (!drop_q) ena_d[ch_q] = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == LEN_W'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    wr_side   = state_d inside {WR_TURN, WR_HDR, WR_DATA, WR_END, WR_FIN};
    rd_side   = state_d inside {RD_TURN, RD_HDR, RD_DATA};
    fd_oe_d   = wr_side;
    fifoadr_d = wr_side ? EP_IN : EP_OUT;
    sloe_d    = !rd_side;
  end

  assign FD_OUT   = fd_out_q;
  assign FD_OE    = fd_oe_q;
  assign SLOE     = sloe_q;
  assign SLRD     = slrd_q;
  assign SLWR     = slwr_q;
  assign PKTEND   = pktend_q;
  assign FIFOADR  = fifoadr_q;
  assign RD_REQ   = rd_req_q;
  assign MSG_SENT = msg_sent_q;
  assign DOUT     = dout_q;
  assign ENA      = ena_q;
  assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_multi_channel_slave_fifo.sv
// Directed bench for multi_channel_slave_fifo: message table plus reset, round-robin and stall sequences.
module tb_multi_channel_slave_fifo;
  localparam int         N_CH   = 4;
  localparam int         CH_W   = 2;
  localparam int         LEN_W  = 8;
  localparam logic [1:0] EP_OUT = 2'b00;
  localparam logic [1:0] EP_IN  = 2'b10;
`ifdef MCSF_PKTEND_EN
  localparam int EXP_PKT = 1;
`else
  localparam int EXP_PKT = 0;
`endif

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  FLAG_EMPTY = 1'b0;
  logic                  FLAG_FULL = 1'b1;
  logic [15:0]           FD_IN = '0;
  logic [15:0]           FD_OUT;
  logic                  FD_OE, SLOE, SLRD, SLWR, PKTEND;
  logic [1:0]            FIFOADR;
  logic [N_CH-1:0]       GOT_FULL_MSG = '0;
  logic [N_CH*LEN_W-1:0] MSG_LEN = '0;
  logic [N_CH*16-1:0]    FIFO_Q = '0;
  logic [N_CH-1:0]       RD_REQ, MSG_SENT, ENA;
  logic [15:0]           DOUT;
  logic [N_CH-1:0]       BUSY = '0;
  logic [7:0]            DROP_CNT;

  always #5 CLK = ~CLK;

  multi_channel_slave_fifo #(
    .N_CH(N_CH), .CH_W(CH_W), .LEN_W(LEN_W), .EP_OUT(EP_OUT), .EP_IN(EP_IN)
  ) dut (
    .CLK(CLK), .RST(RST), .FLAG_EMPTY(FLAG_EMPTY), .FLAG_FULL(FLAG_FULL),
    .FD_IN(FD_IN), .FD_OUT(FD_OUT), .FD_OE(FD_OE), .SLOE(SLOE), .SLRD(SLRD),
    .SLWR(SLWR), .PKTEND(PKTEND), .FIFOADR(FIFOADR), .GOT_FULL_MSG(GOT_FULL_MSG),
    .MSG_LEN(MSG_LEN), .FIFO_Q(FIFO_Q), .RD_REQ(RD_REQ), .MSG_SENT(MSG_SENT),
    .DOUT(DOUT), .ENA(ENA), .BUSY(BUSY), .DROP_CNT(DROP_CNT)
  );

  typedef struct {
    bit         is_wr;
    logic [7:0] ch;
    int         len;
    int         busy_hold;
    logic [15:0] d0, d1, d2;
    logic [7:0] exp_drop;
  } vec_t;

  // Channel FIFOs, host EP_OUT FIFO and serializer models.
  logic [15:0]     ch_fifo [N_CH][$];
  logic [15:0]     host_q [$];
  logic [N_CH-1:0] ready_v = '0;
  logic [N_CH-1:0] busy_force = '0;
  logic [LEN_W-1:0] len_v [N_CH];
  int              busy_cnt [N_CH];

  logic [15:0] wr_words [$];
  logic [15:0] dout_words [$];
  int          msg_order [$];
  int          rd_req_cnt [N_CH];
  int          ena_cnt [N_CH];
  int          slwr_cnt, slrd_cnt, pktend_cnt, viol;
  bit          slwr_prev, slrd_prev;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] tmp;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void refresh();
    for (int c = 0; c < N_CH; c++) begin
      FIFO_Q[c*16 +: 16]        = (ch_fifo[c].size() > 0) ? ch_fifo[c][0] : 16'h0;
      MSG_LEN[c*LEN_W +: LEN_W] = len_v[c];
      BUSY[c]                   = busy_force[c] | (busy_cnt[c] != 0);
    end
    GOT_FULL_MSG = ready_v;
    FD_IN        = (host_q.size() > 0) ? host_q[0] : 16'h0;
    FLAG_EMPTY   = (host_q.size() > 0);
  endfunction

  function automatic void clear_mon();
    wr_words.delete();
    dout_words.delete();
    msg_order.delete();
    for (int c = 0; c < N_CH; c++) begin
      rd_req_cnt[c] = 0;
      ena_cnt[c]    = 0;
    end
    slwr_cnt = 0; slrd_cnt = 0; pktend_cnt = 0;
  endfunction

  // One clock: observe outputs at the falling edge, advance the models, re-drive inputs.
  task automatic step();
    @(negedge CLK);
    if (!RST) begin
      if (!SLWR) begin
        wr_words.push_back(FD_OUT);
        slwr_cnt++;
        if (slwr_prev) viol++;
        if (!FD_OE || FIFOADR != EP_IN) viol++;
      end
      if (!SLRD) begin
        slrd_cnt++;
        if (slrd_prev) viol++;
        if (host_q.size() > 0) tmp = host_q.pop_front();
      end
      if (!PKTEND) begin
        pktend_cnt++;
        if (FIFOADR != EP_IN) viol++;
      end
      for (int c = 0; c < N_CH; c++) begin
        if (RD_REQ[c]) begin
          rd_req_cnt[c]++;
          if (SLWR) viol++;
          if (ch_fifo[c].size() > 0) tmp = ch_fifo[c].pop_front();
        end
        if (MSG_SENT[c]) begin
          msg_order.push_back(c);
          ready_v[c] = 1'b0;
        end
        if (ENA[c]) begin
          ena_cnt[c]++;
          dout_words.push_back(DOUT);
          if (BUSY[c] || SLRD) viol++;
          busy_cnt[c] = 3;
        end else if (busy_cnt[c] > 0) begin
          busy_cnt[c]--;
        end
      end
    end
    slwr_prev = !SLWR;
    slrd_prev = !SLRD;
    refresh();
  endtask

  function automatic logic [15:0] vword(input vec_t v, input int k);
    case (k)
      0:       return v.d0;
      1:       return v.d1;
      default: return v.d2;
    endcase
  endfunction

  task automatic load_ch(input int c, input int len, input logic [15:0] base);
    for (int k = 0; k < len; k++) ch_fifo[c].push_back(base + 16'(k));
    len_v[c]   = LEN_W'(len);
    ready_v[c] = 1'b1;
    refresh();
  endtask

  task automatic wait_sent(input string nm, input int n_msgs);
    int n = 0;
    while (msg_order.size() < n_msgs && n < 400) begin step(); n++; end
    repeat (3) step();
    chk({nm, "_msgs"}, msg_order.size(), n_msgs);
  endtask

  task automatic run_write(input int r, input vec_t v);
    int c = int'(v.ch[1:0]);
    string nm = $sformatf("r%0d_wr", r);
    for (int k = 0; k < v.len; k++) ch_fifo[c].push_back(vword(v, k));
    len_v[c]   = LEN_W'(v.len);
    ready_v[c] = 1'b1;
    refresh();
    wait_sent(nm, 1);
    chk({nm, "_nwords"}, wr_words.size(), v.len + 1);
    if (wr_words.size() > 0) chk({nm, "_hdr"}, wr_words[0], {v.ch, 8'(v.len)});
    for (int k = 0; k < v.len; k++)
      if (k + 1 < wr_words.size()) chk($sformatf("%s_d%0d", nm, k), wr_words[k+1], vword(v, k));
    chk({nm, "_rdreq"}, rd_req_cnt[c], v.len);
    if (msg_order.size() > 0) chk({nm, "_sent_ch"}, msg_order[0], c);
    chk({nm, "_pktend"}, pktend_cnt, EXP_PKT);
    chk({nm, "_idle_bus"}, {FD_OE, FIFOADR, SLWR}, {1'b0, EP_OUT, 1'b1});
  endtask

  task automatic run_read(input int r, input vec_t v);
    int n = 0;
    int tot = 0;
    bit drop = (v.ch >= 8'(N_CH));
    string nm = $sformatf("r%0d_rd", r);
    host_q.push_back({v.ch, 8'(v.len)});
    for (int k = 0; k < v.len; k++) host_q.push_back(vword(v, k));
    if (!drop && v.busy_hold > 0) busy_force[v.ch[1:0]] = 1'b1;
    refresh();
    if (v.busy_hold > 0) begin
      repeat (v.busy_hold) step();
      chk({nm, "_hold_ena"}, ena_cnt[v.ch[1:0]], 0);
      chk({nm, "_hold_slrd"}, slrd_cnt, 1);
      busy_force = '0;
      refresh();
    end
    while ((host_q.size() > 0 || !SLOE) && n < 400) begin step(); n++; end
    repeat (4) step();
    chk({nm, "_drained"}, host_q.size(), 0);
    chk({nm, "_slrd"}, slrd_cnt, v.len + 1);
    for (int c = 0; c < N_CH; c++) tot += ena_cnt[c];
    chk({nm, "_ena_total"}, tot, drop ? 0 : v.len);
    if (!drop) begin
      chk({nm, "_ena_ch"}, ena_cnt[v.ch[1:0]], v.len);
      for (int k = 0; k < v.len; k++)
        if (k < dout_words.size()) chk($sformatf("%s_dout%0d", nm, k), dout_words[k], vword(v, k));
    end
    chk({nm, "_drop_cnt"}, DROP_CNT, v.exp_drop);
    chk({nm, "_sloe"}, SLOE, 1'b1);
  endtask

  vec_t vecs [9];

  initial begin
    int n;
    int s_wr, s_rq;
    vecs[0] = '{1'b1, 8'd2,   3, 0,  16'h1111, 16'h2222, 16'h3333, 8'd0};
    vecs[1] = '{1'b1, 8'd0,   0, 0,  16'h0000, 16'h0000, 16'h0000, 8'd0};
    vecs[2] = '{1'b1, 8'd1,   1, 0,  16'hBEEF, 16'h0000, 16'h0000, 8'd0};
    vecs[3] = '{1'b0, 8'd1,   2, 10, 16'hA5A5, 16'h5A5A, 16'h0000, 8'd0};
    vecs[4] = '{1'b0, 8'd7,   2, 0,  16'h0707, 16'h7070, 16'h0000, 8'd1};
    vecs[5] = '{1'b0, 8'd3,   0, 0,  16'h0000, 16'h0000, 16'h0000, 8'd1};
    vecs[6] = '{1'b0, 8'd0,   3, 0,  16'h0001, 16'h8000, 16'hFFFF, 8'd1};
    vecs[7] = '{1'b0, 8'hFF,  1, 0,  16'h1234, 16'h0000, 16'h0000, 8'd2};
    vecs[8] = '{1'b1, 8'd3,   2, 0,  16'hCAFE, 16'hF00D, 16'h0000, 8'd2};

    for (int c = 0; c < N_CH; c++) begin len_v[c] = '0; busy_cnt[c] = 0; end
    viol = 0;
    clear_mon();
    refresh();
    repeat (2) step();
    chk("rst_strobes", {SLWR, SLRD, SLOE, PKTEND}, 4'hF);
    chk("rst_fifoadr", FIFOADR, EP_OUT);
    chk("rst_fd_oe", FD_OE, 1'b0);
    chk("rst_fd_out", FD_OUT, 16'h0);
    chk("rst_pulses", {RD_REQ, MSG_SENT, ENA}, '0);
    chk("rst_dout", DOUT, 16'h0);
    chk("rst_drop_cnt", DROP_CNT, 8'h0);
    RST = 1'b0;
    repeat (3) step();

    for (int r = 0; r < 9; r++) begin
      clear_mon();
      if (vecs[r].is_wr) run_write(r, vecs[r]);
      else               run_read(r, vecs[r]);
    end

    // Reset in the middle of a data phase abandons the packet.
    clear_mon();
    load_ch(1, 4, 16'h4100);
    n = 0;
    while (rd_req_cnt[1] < 1 && n < 200) begin step(); n++; end
    chk("mid_reset_reached_data", rd_req_cnt[1], 1);
    #2 RST = 1'b1;
    #1;
    chk("mid_reset_strobes", {SLWR, SLRD, SLOE, PKTEND}, 4'hF);
    chk("mid_reset_bus", {FD_OE, FIFOADR}, {1'b0, EP_OUT});
    chk("mid_reset_pulses", {RD_REQ, MSG_SENT}, '0);
    chk("mid_reset_drop_cnt", DROP_CNT, 8'h0);
    ready_v = '0;
    ch_fifo[1].delete();
    refresh();
    repeat (3) step();
    RST = 1'b0;
    clear_mon();
    repeat (10) step();
    chk("mid_reset_no_sent", msg_order.size(), 0);
    chk("mid_reset_no_write", slwr_cnt, 0);

    // Round robin from pointer 0: ch0 then ch3, pointer wraps back to 0.
    clear_mon();
    load_ch(0, 2, 16'h0A01);
    load_ch(3, 1, 16'h3C01);
    wait_sent("rr1", 2);
    if (msg_order.size() == 2) begin
      chk("rr1_first", msg_order[0], 0);
      chk("rr1_second", msg_order[1], 3);
    end
    chk("rr1_nwords", wr_words.size(), 5);
    if (wr_words.size() == 5) begin
      chk("rr1_hdr0", wr_words[0], 16'h0002);
      chk("rr1_d1", wr_words[2], 16'h0A02);
      chk("rr1_hdr3", wr_words[3], 16'h0301);
      chk("rr1_d3", wr_words[4], 16'h3C01);
    end
    clear_mon();
    load_ch(1, 1, 16'h1B01);
    load_ch(3, 1, 16'h3B01);
    wait_sent("rr2", 2);
    if (msg_order.size() == 2) begin
      chk("rr2_first", msg_order[0], 1);
      chk("rr2_second", msg_order[1], 3);
    end

    // Full flag drops mid-message for 5 cycles; no strobes once seen, no lost words.
    clear_mon();
    load_ch(2, 4, 16'h6001);
    n = 0;
    while (rd_req_cnt[2] < 2 && n < 200) begin step(); n++; end
    chk("stall_reached", rd_req_cnt[2], 2);
    FLAG_FULL = 1'b0;
    step();
    s_wr = slwr_cnt;
    s_rq = rd_req_cnt[2];
    repeat (4) step();
    chk("stall_slwr_held", slwr_cnt, s_wr);
    chk("stall_rdreq_held", rd_req_cnt[2], s_rq);
    FLAG_FULL = 1'b1;
    wait_sent("stall", 1);
    chk("stall_nwords", wr_words.size(), 5);
    chk("stall_rdreq", rd_req_cnt[2], 4);
    for (int k = 0; k < 4; k++)
      if (k + 1 < wr_words.size()) chk($sformatf("stall_d%0d", k), wr_words[k+1], 16'h6001 + 16'(k));

    chk("protocol_violations", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
